// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Pixel-timing source for the display pipeline. Free-running horizontal and
// vertical counters produce the current pixel position (DrawX, DrawY), an
// active-high visible-area flag (blank), active-low hs/vs for the connector,
// and a once-per-frame pulse plus frame counter. Game logic uses these to
// update sprite/animation state during vertical blanking.
//
// Ports
//   vga_clk      in   1     pixel clock, sole clock
//   Reset        in   1     synchronous, active-high reset
//   DrawX        out  10    current pixel column, 0..H_TOTAL-1
//   DrawY        out  10    current line, 0..V_TOTAL-1
//   hs           out  1     horizontal sync, active low
//   vs           out  1     vertical sync, active low
//   blank        out  1     1 while (DrawX, DrawY) is inside the visible window
//   frame_start  out  1     one-cycle pulse at (0, V_VISIBLE)
//   frame_count  out  FC_W  frames completed, wraps
//
// Every output is a flop. The sync/blank/frame flags are computed from the
// *next* counter values so that they line up with the DrawX/DrawY presented in
// the same cycle (no one-cycle skew between position and flags).
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int FC_W      = 8
) (
  input  logic            vga_clk,
  input  logic            Reset,
  output logic [9:0]      DrawX,
  output logic [9:0]      DrawY,
  output logic            hs,
  output logic            vs,
  output logic            blank,
  output logic            frame_start,
  output logic [FC_W-1:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // 10-bit versions of the timing boundaries so every compare is same-width.
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_LAST    = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_LAST    = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [9:0]      x_reg, x_next;
  logic [9:0]      y_reg, y_next;
  logic            hs_reg, hs_next;
  logic            vs_reg, vs_next;
  logic            blank_reg, blank_next;
  logic            frame_start_reg, frame_start_next;
  logic [FC_W-1:0] frame_count_reg, frame_count_next;

  // Next position, then all flags decoded from that next position.
  always_comb begin
    x_next           = x_reg;
    y_next           = y_reg;
    hs_next          = 1'b1;
    vs_next          = 1'b1;
    blank_next       = 1'b0;
    frame_start_next = 1'b0;
    frame_count_next = frame_count_reg;

    if (x_reg == H_LAST) begin
      x_next = '0;
      // Vertical counter only moves on the horizontal wrap.
      if (y_reg == V_LAST) begin
        y_next = '0;
      end else begin
        y_next = y_reg + 10'd1;
      end
    end else begin
      x_next = x_reg + 10'd1;
    end

    hs_next          = !((x_next >= HS_FIRST) && (x_next <= HS_LAST));
    vs_next          = !((y_next >= VS_FIRST) && (y_next <= VS_LAST));
    blank_next       = (x_next < H_VIS) && (y_next < V_VIS);
    frame_start_next = (x_next == 10'd0) && (y_next == V_VIS);

    if (frame_start_next) begin
      frame_count_next = frame_count_reg + FC_W'(1);
    end
  end

  // Reset parks the raster at (0,0); the flags take the values that
  // describe that pixel, so the first visible pixel is fully consistent.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      x_reg           <= '0;
      y_reg           <= '0;
      hs_reg          <= 1'b1;
      vs_reg          <= 1'b1;
      blank_reg       <= 1'b1;
      frame_start_reg <= 1'b0;
      frame_count_reg <= '0;
    end else begin
      x_reg           <= x_next;
      y_reg           <= y_next;
      hs_reg          <= hs_next;
      vs_reg          <= vs_next;
      blank_reg       <= blank_next;
      frame_start_reg <= frame_start_next;
      frame_count_reg <= frame_count_next;
    end
  end

  assign DrawX       = x_reg;
  assign DrawY       = y_reg;
  assign hs          = hs_reg;
  assign vs          = vs_reg;
  assign blank       = blank_reg;
  assign frame_start = frame_start_reg;
  assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Two instances share one clock: a default 800x525 raster (line-level and
// reset behaviour) and a small 14x7 raster (whole-frame behaviour, vs,
// frame_start period and frame_count wrap). A positional model derives every
// expected output from the number of clocks elapsed since reset and is
// compared against both instances on every falling edge; directed literal
// checks pin the model to hand-computed values.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  logic vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  logic rst_a, rst_b;

  logic [9:0] a_x, a_y;
  logic       a_hs, a_vs, a_blank, a_fs;
  logic [7:0] a_fc;

  logic [9:0] b_x, b_y;
  logic       b_hs, b_vs, b_blank, b_fs;
  logic [1:0] b_fc;

  vga_timing_gen dut_a (
    .vga_clk     (vga_clk),
    .Reset       (rst_a),
    .DrawX       (a_x),
    .DrawY       (a_y),
    .hs          (a_hs),
    .vs          (a_vs),
    .blank       (a_blank),
    .frame_start (a_fs),
    .frame_count (a_fc)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .FC_W(2)
  ) dut_b (
    .vga_clk     (vga_clk),
    .Reset       (rst_b),
    .DrawX       (b_x),
    .DrawY       (b_y),
    .hs          (b_hs),
    .vs          (b_vs),
    .blank       (b_blank),
    .frame_start (b_fs),
    .frame_count (b_fc)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- positional model ----------------
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       fs;
    logic [7:0] fc;
  } exp_t;

  // p = clocks since the reset edge (0 = the reset state itself).
  function automatic exp_t model(input longint p,
                                 input longint hv, input longint hf, input longint hsw, input longint hb,
                                 input longint vv, input longint vf, input longint vsw, input longint vb,
                                 input longint fcw);
    exp_t   e;
    longint ht, vt, x, y, frames;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    x  = p % ht;
    y  = (p / ht) % vt;
    e.x     = 10'(x);
    e.y     = 10'(y);
    e.hs    = !(x >= hv + hf && x < hv + hf + hsw);
    e.vs    = !(y >= vv + vf && y < vv + vf + vsw);
    e.blank = (x < hv) && (y < vv);
    e.fs    = (x == 0) && (y == vv);
    frames  = (p >= vv * ht) ? ((p - vv * ht) / (ht * vt) + 1) : 0;
    e.fc    = 8'(frames % (longint'(1) << fcw));
    return e;
  endfunction

  longint p_a = 0, p_b = 0;
  bit     v_a = 0, v_b = 0;

  always @(posedge vga_clk) begin
    if (rst_a) begin p_a <= 0; v_a <= 1'b1; end
    else if (v_a) p_a <= p_a + 1;
    if (rst_b) begin p_b <= 0; v_b <= 1'b1; end
    else if (v_b) p_b <= p_b + 1;
  end

  // Single compare process: every cycle, both instances against the model.
  always @(negedge vga_clk) begin
    exp_t ea, eb;
    if (v_a) begin
      ea = model(p_a, 640, 16, 96, 48, 480, 10, 2, 33, 8);
      check("a.DrawX", 32'(a_x), 32'(ea.x));
      check("a.DrawY", 32'(a_y), 32'(ea.y));
      check("a.hs", 32'(a_hs), 32'(ea.hs));
      check("a.vs", 32'(a_vs), 32'(ea.vs));
      check("a.blank", 32'(a_blank), 32'(ea.blank));
      check("a.frame_start", 32'(a_fs), 32'(ea.fs));
      check("a.frame_count", 32'(a_fc), 32'(ea.fc));
    end
    if (v_b) begin
      eb = model(p_b, 8, 2, 2, 2, 4, 1, 1, 1, 2);
      check("b.DrawX", 32'(b_x), 32'(eb.x));
      check("b.DrawY", 32'(b_y), 32'(eb.y));
      check("b.hs", 32'(b_hs), 32'(eb.hs));
      check("b.vs", 32'(b_vs), 32'(eb.vs));
      check("b.blank", 32'(b_blank), 32'(eb.blank));
      check("b.frame_start", 32'(b_fs), 32'(eb.fs));
      check("b.frame_count", 32'(b_fc), 32'(eb.fc));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge vga_clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int hs_lo, bl_hi, first_hs, k, pulses, vs_lo_b, bl_hi_b, hs_lo_b;
    int pulse_t[8];
    int pulse_fc[8];

    rst_a = 1'b1;
    rst_b = 1'b1;
    step(3);
    check("rst.DrawX", 32'(a_x), 0);
    check("rst.DrawY", 32'(a_y), 0);
    check("rst.hs", 32'(a_hs), 1);
    check("rst.vs", 32'(a_vs), 1);
    check("rst.blank", 32'(a_blank), 1);
    check("rst.frame_start", 32'(a_fs), 0);
    check("rst.frame_count", 32'(a_fc), 0);
    $display("txn: reset held 3 cycles, DrawX=%0d DrawY=%0d", a_x, a_y);

    rst_a = 1'b0;
    rst_b = 1'b0;
    step(1);
    check("release.DrawX", 32'(a_x), 1);
    step(798);
    check("eol.DrawX", 32'(a_x), 799);
    check("eol.DrawY", 32'(a_y), 0);
    step(1);
    check("wrap.DrawX", 32'(a_x), 0);
    check("wrap.DrawY", 32'(a_y), 1);
    $display("txn: line 0 wrapped to DrawX=%0d DrawY=%0d", a_x, a_y);

    // One full line: sync and visible widths.
    hs_lo = 0; bl_hi = 0; first_hs = -1;
    for (int i = 0; i < 800; i++) begin
      if (!a_hs) begin
        hs_lo++;
        if (first_hs < 0) first_hs = int'(a_x);
      end
      if (a_blank) bl_hi++;
      step(1);
    end
    check("line.hs_low_cycles", 32'(hs_lo), 96);
    check("line.hs_first_x", 32'(first_hs), 656);
    check("line.blank_high_cycles", 32'(bl_hi), 640);
    $display("txn: line 1 hs_low=%0d first=%0d blank_high=%0d", hs_lo, first_hs, bl_hi);

    // Mid-line reset on the default raster.
    step(300);
    check("mid.DrawX_before", 32'(a_x), 300);
    rst_a = 1'b1;
    step(1);
    rst_a = 1'b0;
    check("mid.DrawX", 32'(a_x), 0);
    check("mid.DrawY", 32'(a_y), 0);
    check("mid.hs", 32'(a_hs), 1);
    check("mid.vs", 32'(a_vs), 1);
    check("mid.blank", 32'(a_blank), 1);
    check("mid.frame_count", 32'(a_fc), 0);
    step(1);
    check("mid.resume_DrawX", 32'(a_x), 1);
    step(5);
    check("mid.resume_DrawX6", 32'(a_x), 6);
    $display("txn: mid-line reset on default raster, resumed at DrawX=%0d", a_x);

    // Small raster: reset mid-frame at (5,3), then observe four frames.
    k = 0;
    while (!(b_x == 10'd5 && b_y == 10'd3) && k < 200) begin
      step(1);
      k++;
    end
    check("b.reach_5_3", 32'(k < 200), 1);
    rst_b = 1'b1;
    step(1);
    rst_b = 1'b0;
    check("b.rst.DrawX", 32'(b_x), 0);
    check("b.rst.DrawY", 32'(b_y), 0);
    check("b.rst.hs", 32'(b_hs), 1);
    check("b.rst.vs", 32'(b_vs), 1);
    check("b.rst.blank", 32'(b_blank), 1);
    check("b.rst.frame_start", 32'(b_fs), 0);
    check("b.rst.frame_count", 32'(b_fc), 0);
    $display("txn: small raster reset at (5,3)");

    pulses = 0; vs_lo_b = 0; bl_hi_b = 0; hs_lo_b = 0;
    for (int i = 0; i < 400; i++) begin
      if (b_fs) begin
        if (pulses < 8) begin
          pulse_t[pulses]  = i;
          pulse_fc[pulses] = int'(b_fc);
        end
        pulses++;
      end
      if (i < 98) begin
        if (!b_vs) vs_lo_b++;
        if (b_blank) bl_hi_b++;
      end
      if (i < 14 && !b_hs) hs_lo_b++;
      step(1);
    end
    check("b.frame.hs_low_cycles", 32'(hs_lo_b), 2);
    check("b.frame.vs_low_cycles", 32'(vs_lo_b), 14);
    check("b.frame.blank_high_cycles", 32'(bl_hi_b), 32);
    check("b.pulse_count", 32'(pulses), 4);
    if (pulses >= 4) begin
      check("b.first_pulse_cycle", 32'(pulse_t[0]), 56);
      for (int j = 1; j < 4; j++)
        check("b.frame_period", 32'(pulse_t[j] - pulse_t[j-1]), 98);
      check("b.fc_pulse1", 32'(pulse_fc[0]), 1);
      check("b.fc_pulse2", 32'(pulse_fc[1]), 2);
      check("b.fc_pulse3", 32'(pulse_fc[2]), 3);
      check("b.fc_pulse4_wrap", 32'(pulse_fc[3]), 0);
    end
    $display("txn: small raster %0d pulses, vs_low=%0d blank_high=%0d", pulses, vs_lo_b, bl_hi_b);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Pixel-timing source for the display pipeline.
- Free-running horizontal/vertical counters drive DrawX/DrawY, active-high blank (1 = visible pixel), and active-low hs/vs for the VGA connector.
- Also produces a once-per-frame pulse and frame counter so game logic (sprite movement, animation) updates during vertical blanking.
- Consumers are all sprite/background renderers and the colour mux.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks); H_TOTAL = sum = 800
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines); V_TOTAL = sum = 525
- FC_W, 8, frame_count width

Ports:
- vga_clk  in  1  pixel clock (25 MHz nominal); sole clock
- Reset  in  1  synchronous, active-high reset
- DrawX  out  10  current pixel column, 0..H_TOTAL-1
- DrawY  out  10  current line, 0..V_TOTAL-1
- hs  out  1  horizontal sync, active low
- vs  out  1  vertical sync, active low
- blank  out  1  1 when DrawX<H_VISIBLE and DrawY<V_VISIBLE, else 0
- frame_start  out  1  one-cycle pulse at first blanked line start
- frame_count  out  FC_W  frames completed, wraps

Behaviour:
- One clock (vga_clk). Reset is synchronous and active-high; port named Reset.
- All outputs are registered; no combinational path from any input to any output.
- hs, vs, blank, frame_start always describe the same (DrawX, DrawY) presented in that cycle (zero skew). Implementation: compute them from next-state counter values.
- Reset (sampled high at an edge), next cycle:
  - DrawX=0, DrawY=0, hs=1, vs=1, blank=1, frame_start=0, frame_count=0.
  - Held while Reset stays high.
  - First edge after release advances to DrawX=1.
- Reset mid-frame: same values the following cycle; no partial-line completion.
- Horizontal counter:
  - DrawX increments by 1 every cycle.
  - At DrawX=H_TOTAL-1, next DrawX=0.
- Vertical counter:
  - DrawY increments only on the cycle DrawX wraps.
  - At DrawX=H_TOTAL-1 and DrawY=V_TOTAL-1, next DrawX=0, DrawY=0 (both wrap the same edge).
- hs=0 iff H_VISIBLE+H_FP <= DrawX <= H_VISIBLE+H_FP+H_SYNC-1 (default 656..751).
- vs=0 iff V_VISIBLE+V_FP <= DrawY <= V_VISIBLE+V_FP+V_SYNC-1 (default 490..491); held for whole lines.
- blank=1 only inside the visible window. Default: 640 cycles high, 160 low per visible line; low all of lines 480..524.
- frame_start=1 for exactly the single cycle where DrawX=0 and DrawY=V_VISIBLE; 0 otherwise, including during reset.
- frame_count increments by 1 in the same cycle frame_start goes high; wraps 2^FC_W-1 -> 0.
- Period: exactly H_TOTAL*V_TOTAL cycles per frame (default 420000).
- Arithmetic: counters are 10-bit unsigned; parameters must satisfy H_TOTAL<=1024 and V_TOTAL<=1024.

Test Plan:
- Reset for 3 cycles, release -> DrawX=0,DrawY=0,blank=1,hs=1,vs=1 during reset; DrawX=1 one cycle after release; DrawX=799 then DrawX=0,DrawY=1.
- Run one line -> hs low exactly at DrawX 656..751 (96 cycles); blank high DrawX 0..639, low 640..799.
- Run full frame -> vs low for lines 490..491 (1600 cycles); blank never high for DrawY>=480; DrawY 524,DrawX 799 -> next 0,0; frame period 420000 cycles.
- Count frames -> frame_start single-cycle pulse at (0,480) each frame, none elsewhere; frame_count 0->1->2 across three frames.
- Override params (H 8/2/2/2, V 4/1/1/1, FC_W=2) -> H_TOTAL=14, V_TOTAL=7, 98-cycle frames; frame_count wraps 3->0 on 4th pulse.
- Assert Reset at DrawX=300,DrawY=200 for 1 cycle -> next cycle 0,0 with hs=vs=blank=1, frame_count=0; resumes counting normally.
